// File: rtl/debug_trace_pkg.sv
// Shared types and constants for the debug trace serializer.
package debug_trace_pkg;

    localparam logic [3:0]  TRACE_WEN_ALL = 4'hf;
    localparam int unsigned TRACE_PC_W    = 32;
    localparam int unsigned TRACE_DATA_W  = 32;

    // Default entry layout; the top re-declares it with its own widths.
    typedef struct packed {
        logic [4:0]              rd;
        logic [TRACE_DATA_W-1:0] wdata;
        logic [TRACE_PC_W-1:0]   pc;
    } wb_entry_t;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Two-write/one-read circular buffer; din1 is stored behind din0 when both are pushed.
module trace_fifo_2w1r
    import debug_trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = wb_entry_t,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push0,
    input  entry_t        din0,
    input  logic          push1,
    input  entry_t        din1,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_idx1;

    always_comb begin
        mem_d   = mem_q;
        wr_idx1 = push0 ? wr_ptr_q + AW'(1) : wr_ptr_q;
        if (push0) mem_d[wr_ptr_q] = din0;
        if (push1) mem_d[wr_idx1] = din1;
        wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/debug_trace_serializer.sv
// Merges two writeback slots into one single-issue debug trace stream with stall/overflow.
// Optional macro DEBUG_TRACE_SEQ_EN adds a 32-bit emitted-write sequence number output.
module debug_trace_serializer
    import debug_trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wb0_en,
    input  logic [4:0]        wb0_rd,
    input  logic [DATA_W-1:0] wb0_wdata,
    input  logic [PC_W-1:0]   wb0_pc,
    input  logic              wb1_en,
    input  logic [4:0]        wb1_rd,
    input  logic [DATA_W-1:0] wb1_wdata,
    input  logic [PC_W-1:0]   wb1_pc,
    output logic              trace_stall,
    output logic              trace_overflow,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
`ifdef DEBUG_TRACE_SEQ_EN
    output logic [31:0]       debug_wb_seq,
`endif
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] wdata;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t        e0, e1, head, cand0, cand1, out_q, out_d;
    logic          acc0, acc1, fifo_empty, pop, emit, push0, push1;
    logic          wen_q, wen_d, overflow_q, overflow_d;
    logic [1:0]    n_cand;
    logic [CW-1:0] count, room;

    assign e0 = '{rd: wb0_rd, wdata: wb0_wdata, pc: wb0_pc};
    assign e1 = '{rd: wb1_rd, wdata: wb1_wdata, pc: wb1_pc};

    always_comb begin
        acc0       = wb0_en && (wb0_rd != 5'd0);
        acc1       = wb1_en && (wb1_rd != 5'd0);
        fifo_empty = (count == '0);
        pop        = !fifo_empty;
        emit       = pop || acc0 || acc1;
        out_d      = out_q;
        cand0      = e0;
        cand1      = e1;
        n_cand     = 2'd0;
        if (fifo_empty) begin
            // Oldest accepted slot bypasses the FIFO; only a second one is buffered.
            if (emit) out_d = acc0 ? e0 : e1;
            cand0  = e1;
            n_cand = {1'b0, acc0 && acc1};
        end else begin
            out_d  = head;
            cand0  = acc0 ? e0 : e1;
            n_cand = 2'(acc0) + 2'(acc1);
        end
        // Slot freed by this edge's pop is reusable for a push in the same edge.
        room       = CW'(DEPTH) - count + CW'(pop);
        push0      = (n_cand != 2'd0) && (room != '0);
        push1      = (n_cand == 2'd2) && (room >= CW'(2));
        overflow_d = overflow_q || (push0 != (n_cand != 2'd0)) || (push1 != (n_cand == 2'd2));
        wen_d      = emit;
    end

    trace_fifo_2w1r #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push0  (push0),
        .din0   (cand0),
        .push1  (push1),
        .din1   (cand1),
        .pop    (pop),
        .head   (head),
        .count  (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q      <= '0;
            wen_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            wen_q      <= wen_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef DEBUG_TRACE_SEQ_EN
    logic [31:0] seq_q, seq_d;

    always_comb begin
        seq_d = seq_q;
        if (emit) seq_d = seq_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) seq_q <= '0;
        else         seq_q <= seq_d;
    end

    assign debug_wb_seq = seq_q;
`endif

    assign trace_stall       = (count >= CW'(DEPTH - 2));
    assign trace_overflow    = overflow_q;
    assign debug_wb_rf_wen   = wen_q ? TRACE_WEN_ALL : 4'h0;
    assign debug_wb_pc       = out_q.pc;
    assign debug_wb_rf_wnum  = out_q.rd;
    assign debug_wb_rf_wdata = out_q.wdata;

endmodule

// File: tb/tb_debug_trace_serializer.sv
// Self-checking bench: queue-based reference model of the trace serializer, random + directed.
module tb_debug_trace_serializer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb0_en = 1'b0, wb1_en = 1'b0;
    logic [4:0]  wb0_rd = '0, wb1_rd = '0;
    logic [31:0] wb0_wdata = '0, wb1_wdata = '0, wb0_pc = '0, wb1_pc = '0;
    logic        trace_stall, trace_overflow;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
`ifdef DEBUG_TRACE_SEQ_EN
    logic [31:0] debug_wb_seq;
`endif

    always #5 clk = ~clk;

    debug_trace_serializer #(
        .DEPTH  (DEPTH),
        .PC_W   (32),
        .DATA_W (32)
    ) u_dut (
        .clk               (clk),
        .resetn            (resetn),
        .wb0_en            (wb0_en),
        .wb0_rd            (wb0_rd),
        .wb0_wdata         (wb0_wdata),
        .wb0_pc            (wb0_pc),
        .wb1_en            (wb1_en),
        .wb1_rd            (wb1_rd),
        .wb1_wdata         (wb1_wdata),
        .wb1_pc            (wb1_pc),
        .trace_stall       (trace_stall),
        .trace_overflow    (trace_overflow),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
`ifdef DEBUG_TRACE_SEQ_EN
        .debug_wb_seq      (debug_wb_seq),
`endif
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
    } ent_t;

    // Reference model: pending writes in order, plus the expected output register.
    ent_t        q[$];
    logic [3:0]  m_wen;
    logic [31:0] m_pc, m_wdata, m_seq;
    logic [4:0]  m_wnum;
    logic        m_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_reset();
        q.delete();
        m_wen = '0; m_pc = '0; m_wdata = '0; m_wnum = '0; m_ovf = 1'b0; m_seq = '0;
    endfunction

    function automatic logic [72:0] m_out();
        return {m_wen, m_pc, m_wnum, m_wdata};
    endfunction

    function automatic logic [72:0] d_out();
        return {debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};
    endfunction

    function automatic void model_emit(input ent_t e);
        m_wen = 4'hf; m_pc = e.pc; m_wnum = e.rd; m_wdata = e.wdata; m_seq = m_seq + 32'd1;
    endfunction

    // Drive one cycle of writeback, clock it, and advance the model by the plain rules.
    task automatic cycle(input logic en0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic [31:0] pc0, input logic en1, input logic [4:0] rd1,
                         input logic [31:0] d1, input logic [31:0] pc1);
        ent_t acc[$];
        ent_t e;
        wb0_en = en0; wb0_rd = rd0; wb0_wdata = d0; wb0_pc = pc0;
        wb1_en = en1; wb1_rd = rd1; wb1_wdata = d1; wb1_pc = pc1;
        @(posedge clk);
        if (resetn) begin
            if (en0 && rd0 != 5'd0) acc.push_back('{rd0, d0, pc0});
            if (en1 && rd1 != 5'd0) acc.push_back('{rd1, d1, pc1});
            m_wen = 4'h0;
            if (q.size() > 0) begin
                e = q.pop_front();
                model_emit(e);
            end else if (acc.size() > 0) begin
                e = acc.pop_front();
                model_emit(e);
            end
            foreach (acc[i]) begin
                if (q.size() < DEPTH) q.push_back(acc[i]);
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        wb0_en = 1'b1; wb0_rd = 5'd5; wb0_wdata = 32'hdead; wb0_pc = 32'hbfc00100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({d_out(), trace_stall, trace_overflow} !== 75'd0) begin
                n_fail++;
                $display("FAIL reset_hold: outputs=%h required 0", {d_out(), trace_stall, trace_overflow});
            end
        end
        wb0_en = 1'b0;
        resetn = 1'b1;
        idle();
        n_checks++;
        if (debug_wb_rf_wen !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release_idle: wen=%h required 0", debug_wb_rf_wen);
        end
        cycle(1'b1, 5'd5, 32'h55, 32'hbfc00004, 1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++;
        if (d_out() !== m_out() || m_wen !== 4'hf) begin
            n_fail++;
            $display("FAIL reset_first_write: out=%h required %h", d_out(), m_out());
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 5'd3, 32'h1234, 32'hbfc00000, 1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++;
        if (d_out() !== {4'hf, 32'hbfc00000, 5'd3, 32'h1234}) begin
            n_fail++;
            $display("FAIL single_emit: out=%h required %h", d_out(),
                     {4'hf, 32'hbfc00000, 5'd3, 32'h1234});
        end
        idle();
        n_checks++;
        if (d_out() !== {4'h0, 32'hbfc00000, 5'd3, 32'h1234}) begin
            n_fail++;
            $display("FAIL single_hold: out=%h required %h", d_out(),
                     {4'h0, 32'hbfc00000, 5'd3, 32'h1234});
        end
    endtask

    task automatic test_dual_order();
        cycle(1'b1, 5'd1, 32'ha1, 32'hbfc00010, 1'b1, 5'd2, 32'ha2, 32'hbfc00014);
        n_checks++;
        if (d_out() !== m_out() || debug_wb_rf_wnum !== 5'd1 || trace_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_first: out=%h stall=%b required %h stall=0", d_out(),
                     trace_stall, m_out());
        end
        idle();
        n_checks++;
        if (d_out() !== m_out() || debug_wb_rf_wnum !== 5'd2 || debug_wb_pc !== 32'hbfc00014) begin
            n_fail++;
            $display("FAIL dual_second: out=%h required %h", d_out(), m_out());
        end
    endtask

    task automatic test_r0_filter();
        cycle(1'b1, 5'd0, 32'hbad, 32'hbfc00020, 1'b1, 5'd7, 32'h77, 32'hbfc00024);
        n_checks++;
        if (d_out() !== {4'hf, 32'hbfc00024, 5'd7, 32'h77}) begin
            n_fail++;
            $display("FAIL r0_bypass: out=%h required %h", d_out(),
                     {4'hf, 32'hbfc00024, 5'd7, 32'h77});
        end
        idle();
        n_checks++;
        if (debug_wb_rf_wen !== 4'h0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL r0_no_extra: wen=%h required 0", debug_wb_rf_wen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc_next = 32'h80000000;
        logic [31:0] pc_exp  = 32'h80000000;
        int issued = 0, traced = 0, stall_seen = 0, order_bad = 0, stall_bad = 0;
        for (int c = 0; c < 120 && traced < 40; c++) begin
            if (!trace_stall && issued < 40) begin
                cycle(1'b1, 5'd9, pc_next ^ 32'h5a5a, pc_next,
                      1'b1, 5'd10, pc_next ^ 32'ha5a5, pc_next + 32'd4);
                pc_next += 32'd8;
                issued  += 2;
            end else begin
                idle();
            end
            if (debug_wb_rf_wen == 4'hf) begin
                if (debug_wb_pc !== pc_exp) order_bad++;
                pc_exp += 32'd4;
                traced++;
            end
            if (trace_stall !== (q.size() >= DEPTH - 2)) stall_bad++;
            if (trace_stall === 1'b1) stall_seen++;
        end
        n_checks++;
        if (stall_bad != 0 || stall_seen == 0) begin
            n_fail++;
            $display("FAIL b2b_stall: bad_cycles=%0d stall_cycles=%0d required 0 and >0",
                     stall_bad, stall_seen);
        end
        n_checks++;
        if (order_bad != 0 || traced != 40) begin
            n_fail++;
            $display("FAIL b2b_order: misordered=%0d traced=%0d required 0 and 40",
                     order_bad, traced);
        end
        n_checks++;
        if (trace_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_overflow: overflow=%b required 0", trace_overflow);
        end
    endtask

    task automatic test_overflow();
        int bad = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, 5'(c + 1), 32'(c * 3), 32'h90000000 + 32'(c * 8),
                  1'b1, 5'(c + 17), 32'(c * 5), 32'h90000004 + 32'(c * 8));
            if (d_out() !== m_out() || trace_stall !== (q.size() >= DEPTH - 2)
                || u_dut.count > 4'(DEPTH) || u_dut.count !== 4'(q.size())) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ovf_burst: bad_cycles=%0d required 0", bad);
        end
        n_checks++;
        if (trace_overflow !== m_ovf || m_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: overflow=%b required %b", trace_overflow, m_ovf);
        end
        bad = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            idle();
            if (d_out() !== m_out()) bad++;
`ifdef DEBUG_TRACE_SEQ_EN
            if (debug_wb_seq !== m_seq) bad++;
`endif
        end
        n_checks++;
        if (bad != 0 || trace_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain_sticky: bad_cycles=%0d overflow=%b required 0 and 1",
                     bad, trace_overflow);
        end
        resetn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({d_out(), trace_stall, trace_overflow} !== 75'd0) begin
            n_fail++;
            $display("FAIL ovf_reset_clear: outputs=%h required 0",
                     {d_out(), trace_stall, trace_overflow});
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_random();
        int bad_out = 0, bad_flags = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                cycle(1'b1, 5'd4, 32'd1, 32'd2, 1'b1, 5'd6, 32'd3, 32'd4);
                resetn = 1'b0;
                model_reset();
                #1;
                if ({d_out(), trace_overflow, trace_stall} !== 75'd0) bad_out++;
                @(negedge clk);
                resetn = 1'b1;
            end
            if (c >= 100 && c < 140 || !trace_stall || $urandom_range(0, 3) == 0) begin
                cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 4) == 0 ? 0 : $urandom),
                      $urandom, $urandom,
                      $urandom_range(0, 2) != 0, 5'($urandom_range(0, 4) == 0 ? 0 : $urandom),
                      $urandom, $urandom);
            end else begin
                idle();
            end
            if (d_out() !== m_out()) bad_out++;
`ifdef DEBUG_TRACE_SEQ_EN
            if (debug_wb_seq !== m_seq) bad_out++;
`endif
            if (trace_stall !== (q.size() >= DEPTH - 2) || trace_overflow !== m_ovf) bad_flags++;
        end
        n_checks++;
        if (bad_out != 0) begin
            n_fail++;
            $display("FAIL random_outputs: bad_cycles=%0d required 0", bad_out);
        end
        n_checks++;
        if (bad_flags != 0) begin
            n_fail++;
            $display("FAIL random_stall_overflow: bad_cycles=%0d required 0", bad_flags);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_order();
        test_r0_filter();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
